demux_l2: RTL and testbench



---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_l2.sv | 66 ++++++
 tb/tb_demux_l2.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and default widths for the 1-to-2 lane demultiplexer.
package demux_pkg;

  localparam int unsigned BUS_W_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic {
    WAIT_L0 = 1'b0,
    WAIT_L1 = 1'b1
  } state_t;

endpackage

// File: rtl/demux_l2.sv
// 1-to-2 lane demux: splits an interleaved lane0/lane1 byte stream back into two lanes.
// Optional macro DEMUX_GAP_FLUSH_EN: an idle cycle while a lane0 byte is held flushes it alone.
module demux_l2
  import demux_pkg::*;
#(
  parameter int unsigned BUS_W = BUS_W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [BUS_W-1:0] Entrada,
  input  logic             validEntrada,
  output logic [BUS_W-1:0] Salida0,
  output logic [BUS_W-1:0] Salida1,
  output logic             validSalida0,
  output logic             validSalida1,
  output logic [CNT_W-1:0] pair_count
);

  state_t           state;
  logic [BUS_W-1:0] hold;

  // Pair assembly FSM; reset wins over any byte presented in the same cycle.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state        <= WAIT_L0;
      hold         <= '0;
      Salida0      <= '0;
      Salida1      <= '0;
      validSalida0 <= 1'b0;
      validSalida1 <= 1'b0;
      pair_count   <= '0;
    end else begin
      validSalida0 <= 1'b0;
      validSalida1 <= 1'b0;
      case (state)
        WAIT_L0: begin
          if (validEntrada) begin
            hold  <= Entrada;
            state <= WAIT_L1;
          end
        end
        WAIT_L1: begin
          if (validEntrada) begin
            Salida0      <= hold;
            Salida1      <= Entrada;
            validSalida0 <= 1'b1;
            validSalida1 <= 1'b1;
            pair_count   <= pair_count + CNT_W'(1);
            state        <= WAIT_L0;
          end
`ifdef DEMUX_GAP_FLUSH_EN
          else begin
            // Emit the orphaned lane0 byte; lane1 output keeps its old value.
            Salida0      <= hold;
            validSalida0 <= 1'b1;
            state        <= WAIT_L0;
          end
`endif
        end
        default: state <= WAIT_L0;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_l2.sv
// Directed self-checking bench for demux_l2; outputs compared as one packed word per cycle.
module tb_demux_l2;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] Entrada;
  logic       validEntrada;
  logic [7:0] Salida0;
  logic [7:0] Salida1;
  logic       validSalida0;
  logic       validSalida1;
  logic [7:0] pair_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [25:0] obs;
  assign obs = {Salida0, Salida1, validSalida0, validSalida1, pair_count};

  demux_l2 dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .Entrada     (Entrada),
    .validEntrada(validEntrada),
    .Salida0     (Salida0),
    .Salida1     (Salida1),
    .validSalida0(validSalida0),
    .validSalida1(validSalida1),
    .pair_count  (pair_count)
  );

  always #5 clk_4f = ~clk_4f;

  function automatic logic [25:0] pk(input logic [7:0] s0, input logic [7:0] s1,
                                     input logic v0, input logic v1, input logic [7:0] c);
    return {s0, s1, v0, v1, c};
  endfunction

  // Apply inputs for one cycle, then sample just after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    reset = r;
    validEntrada = v;
    Entrada = d;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (obs !== pk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, pk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      n_tests++;
      if (obs !== pk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00)) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs, pk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [25:0] exp_v [5];
    logic [7:0]  din   [5];
    logic        vin   [5];
    cyc(1'b1, 1'b0, 8'h00);
    din = '{8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'h00};
    vin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_v[0] = pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
    exp_v[1] = pk(8'hA1, 8'hB1, 1'b1, 1'b1, 8'd1);
    exp_v[2] = pk(8'hA1, 8'hB1, 1'b0, 1'b0, 8'd1);
    exp_v[3] = pk(8'hA2, 8'hB2, 1'b1, 1'b1, 8'd2);
    exp_v[4] = pk(8'hA2, 8'hB2, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, vin[i], din[i]);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_gap;
    logic [25:0] exp_v [6];
    logic [7:0]  din   [6];
    logic        vin   [6];
    cyc(1'b1, 1'b0, 8'h00);
    din = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h22, 8'h33};
    vin = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_v[0] = pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
`ifdef DEMUX_GAP_FLUSH_EN
    exp_v[1] = pk(8'h11, 8'h00, 1'b1, 1'b0, 8'd0);
    exp_v[2] = pk(8'h11, 8'h00, 1'b0, 1'b0, 8'd0);
    exp_v[3] = pk(8'h11, 8'h00, 1'b0, 1'b0, 8'd0);
    exp_v[4] = pk(8'h11, 8'h00, 1'b0, 1'b0, 8'd0);
    exp_v[5] = pk(8'h22, 8'h33, 1'b1, 1'b1, 8'd1);
`else
    exp_v[1] = pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
    exp_v[2] = pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
    exp_v[3] = pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
    exp_v[4] = pk(8'h11, 8'h22, 1'b1, 1'b1, 8'd1);
    exp_v[5] = pk(8'h11, 8'h22, 1'b0, 1'b0, 8'd1);
`endif
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, vin[i], din[i]);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL gap[%0d]: got %h expected %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_pair;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h5A);
    cyc(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (obs !== pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0)) begin
      n_fail++;
      $display("FAIL mid_pair_reset: got %h expected %h", obs, pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0));
    end
    cyc(1'b0, 1'b1, 8'h01);
    n_tests++;
    if (obs !== pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0)) begin
      n_fail++;
      $display("FAIL mid_pair_first: got %h expected %h", obs, pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0));
    end
    cyc(1'b0, 1'b1, 8'h02);
    n_tests++;
    if (obs !== pk(8'h01, 8'h02, 1'b1, 1'b1, 8'd1)) begin
      n_fail++;
      $display("FAIL mid_pair_pair: got %h expected %h", obs, pk(8'h01, 8'h02, 1'b1, 1'b1, 8'd1));
    end
  endtask

  task automatic test_wrap;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] ec;
    cyc(1'b1, 1'b0, 8'h00);
    e0 = 8'h00;
    e1 = 8'h00;
    ec = 8'h00;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b1, 8'(i));
      n_tests++;
      if (obs !== pk(e0, e1, 1'b0, 1'b0, ec)) begin
        n_fail++;
        $display("FAIL wrap_lane0[%0d]: got %h expected %h", i, obs, pk(e0, e1, 1'b0, 1'b0, ec));
      end
      cyc(1'b0, 1'b1, ~8'(i));
      e0 = 8'(i);
      e1 = ~8'(i);
      ec = 8'(i + 1);
      n_tests++;
      if (obs !== pk(e0, e1, 1'b1, 1'b1, ec)) begin
        n_fail++;
        $display("FAIL wrap_pair[%0d]: got %h expected %h", i, obs, pk(e0, e1, 1'b1, 1'b1, ec));
      end
    end
    n_tests++;
    if (pair_count !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_count: got %h expected 00", pair_count);
    end
  endtask

  task automatic test_collision;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hC1);
    cyc(1'b0, 1'b1, 8'hC2);
    cyc(1'b1, 1'b1, 8'hFF);
    n_tests++;
    if (obs !== pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0)) begin
      n_fail++;
      $display("FAIL collision_l0: got %h expected %h", obs, pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0));
    end
    cyc(1'b0, 1'b1, 8'h77);
    cyc(1'b1, 1'b1, 8'hFF);
    n_tests++;
    if (obs !== pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0)) begin
      n_fail++;
      $display("FAIL collision_l1: got %h expected %h", obs, pk(8'h00, 8'h00, 1'b0, 1'b0, 8'd0));
    end
    cyc(1'b0, 1'b1, 8'h10);
    cyc(1'b0, 1'b1, 8'h20);
    n_tests++;
    if (obs !== pk(8'h10, 8'h20, 1'b1, 1'b1, 8'd1)) begin
      n_fail++;
      $display("FAIL collision_after: got %h expected %h", obs, pk(8'h10, 8'h20, 1'b1, 1'b1, 8'd1));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_reset_mid_pair();
    test_wrap();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
